// File: rtl/lvds_rx_pll_sequencer_if.sv
// Interface between the LVDS RX PLL sequencer and the PLL wrapper / RX datapath.
//   master : the sequencer (reads lock/alignment status and realign, drives controls)
//   slave  : the PLL wrapper / datapath side (drives status, receives controls)
// Signals:
//   pll_locked     PLL lock, asynchronous to the sequencer clock
//   align_match    datapath reports the training word is aligned
//   realign        one-cycle request to redo RX reset and alignment
//   pll_rst        PLL reset, active high
//   rx_rst         deserializer/datapath reset, active high
//   bitslip        one-cycle bitslip pulse
//   ready          link aligned and usable
//   align_fail     every slip position tried without a match
//   timeout_count  saturating count of lock timeouts
//   relock_count   saturating count of lock losses after qualification
//   state          current sequencer state (debug)
interface lvds_rx_pll_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             align_match;
  logic             realign;
  logic             pll_rst;
  logic             rx_rst;
  logic             bitslip;
  logic             ready;
  logic             align_fail;
  logic [CNT_W-1:0] timeout_count;
  logic [CNT_W-1:0] relock_count;
  logic [2:0]       state;

  modport master (
    input  pll_locked, align_match, realign,
    output pll_rst, rx_rst, bitslip, ready, align_fail,
           timeout_count, relock_count, state
  );

  modport slave (
    output pll_locked, align_match, realign,
    input  pll_rst, rx_rst, bitslip, ready, align_fail,
           timeout_count, relock_count, state
  );
endinterface

// File: rtl/lvds_rx_pll_sequencer.sv
// Bring-up and recovery controller for the 6x LVDS receive PLL and deserializer.
// Holds the PLL in reset, qualifies lock through a 2-FF synchroniser and a
// stability window, pulses the deserializer reset, then steps bitslip until the
// datapath reports word alignment. Any lock loss after qualification restarts
// the whole sequence. All outputs are registered.
// Ports:
//   clk    free-running control clock
//   rst_n  asynchronous active-low reset
//   bus    lvds_rx_pll_sequencer_if.master (status in, controls/counters/state out)
module lvds_rx_pll_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int RX_RST_CYCLES = 8,
  parameter int SLIP_WAIT     = 8,
  parameter int DESER_FACTOR  = 6,
  parameter int CNT_W         = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  lvds_rx_pll_sequencer_if.master        bus
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX   = max_of(max_of(max_of(RST_CYCLES, LOCK_TIMEOUT),
                                         max_of(STABLE_CYCLES, RX_RST_CYCLES)),
                                  SLIP_WAIT);
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam int SLIP_W  = $clog2(DESER_FACTOR + 1);

  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RXR_LAST    = TIMER_W'(RX_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SLIP_LAST   = TIMER_W'(SLIP_WAIT - 1);
  localparam logic [SLIP_W-1:0]  SLIP_MAX    = SLIP_W'(DESER_FACTOR - 1);

  typedef enum logic [2:0] {
    ST_RESET_PLL  = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RX_RST     = 3'd3,
    ST_ALIGN      = 3'd4,
    ST_ALIGN_FAIL = 3'd5,
    ST_READY      = 3'd6
  } state_e;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [SLIP_W-1:0]  slip_q;
  logic               pll_rst_q;
  logic               rx_rst_q;
  logic               bitslip_q;
  logic               ready_q;
  logic               align_fail_q;
  logic [CNT_W-1:0]   timeout_q;
  logic [CNT_W-1:0]   relock_q;
  logic [1:0]         sync_q;

  logic locked_s;
  logic lock_watch;
  logic realign_ok;

  assign locked_s   = sync_q[1];
  // Lock is only supervised once it has been qualified.
  assign lock_watch = state_q inside {ST_RX_RST, ST_ALIGN, ST_ALIGN_FAIL, ST_READY};
  assign realign_ok = state_q inside {ST_RX_RST, ST_ALIGN_FAIL, ST_READY};

  // pll_locked is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.pll_locked};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET_PLL;
      timer_q      <= '0;
      slip_q       <= '0;
      pll_rst_q    <= 1'b1;
      rx_rst_q     <= 1'b1;
      bitslip_q    <= 1'b0;
      ready_q      <= 1'b0;
      align_fail_q <= 1'b0;
      timeout_q    <= '0;
      relock_q     <= '0;
    end else begin
      bitslip_q <= 1'b0;
      if (lock_watch && !locked_s) begin
        state_q      <= ST_RESET_PLL;
        timer_q      <= '0;
        slip_q       <= '0;
        pll_rst_q    <= 1'b1;
        rx_rst_q     <= 1'b1;
        ready_q      <= 1'b0;
        align_fail_q <= 1'b0;
        relock_q     <= sat_inc(relock_q);
      end else if (realign_ok && bus.realign) begin
        state_q      <= ST_RX_RST;
        timer_q      <= '0;
        slip_q       <= '0;
        rx_rst_q     <= 1'b1;
        ready_q      <= 1'b0;
        align_fail_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_RESET_PLL: begin
            if (timer_q == RST_LAST) begin
              state_q   <= ST_WAIT_LOCK;
              timer_q   <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked_s) begin
              state_q <= ST_STABLE;
              timer_q <= '0;
            end else if (timer_q == LOCK_LAST) begin
              state_q   <= ST_RESET_PLL;
              timer_q   <= '0;
              pll_rst_q <= 1'b1;
              timeout_q <= sat_inc(timeout_q);
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_STABLE: begin
            // A single low sample drops back to WAIT_LOCK; the window restarts on re-lock.
            if (!locked_s) begin
              state_q <= ST_WAIT_LOCK;
              timer_q <= '0;
            end else if (timer_q == STABLE_LAST) begin
              state_q <= ST_RX_RST;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_RX_RST: begin
            if (timer_q == RXR_LAST) begin
              state_q  <= ST_ALIGN;
              timer_q  <= '0;
              slip_q   <= '0;
              rx_rst_q <= 1'b0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_ALIGN: begin
            // The settle window restarts on the bitslip cycle, so two slips can
            // never land on consecutive cycles even with SLIP_WAIT of 1.
            if (timer_q == SLIP_LAST && !bitslip_q) begin
              timer_q <= '0;
              if (bus.align_match) begin
                state_q <= ST_READY;
                ready_q <= 1'b1;
              end else if (slip_q < SLIP_MAX) begin
                bitslip_q <= 1'b1;
                slip_q    <= slip_q + 1'b1;
              end else begin
                state_q      <= ST_ALIGN_FAIL;
                align_fail_q <= 1'b1;
              end
            end else if (timer_q != SLIP_LAST) begin
              timer_q <= timer_q + 1'b1;
            end
          end
          ST_ALIGN_FAIL, ST_READY: begin
          end
          default: begin
            state_q   <= ST_RESET_PLL;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            rx_rst_q  <= 1'b1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.rx_rst        = rx_rst_q;
  assign bus.bitslip       = bitslip_q;
  assign bus.ready         = ready_q;
  assign bus.align_fail    = align_fail_q;
  assign bus.timeout_count = timeout_q;
  assign bus.relock_count  = relock_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_lvds_rx_pll_sequencer.sv
// Testbench for lvds_rx_pll_sequencer: scoreboard of expected results pushed
// when stimulus is applied and popped when the DUT reaches the matching point.
module tb_lvds_rx_pll_sequencer;
  localparam int CNT_W = 8;
  localparam int S_RESET_PLL  = 0;
  localparam int S_WAIT_LOCK  = 1;
  localparam int S_STABLE     = 2;
  localparam int S_RX_RST     = 3;
  localparam int S_ALIGN      = 4;
  localparam int S_ALIGN_FAIL = 5;
  localparam int S_READY      = 6;

  logic clk = 1'b0;
  logic rst_n;

  lvds_rx_pll_sequencer_if #(.CNT_W(CNT_W)) bus ();

  lvds_rx_pll_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .RX_RST_CYCLES(3),
    .SLIP_WAIT    (2),
    .DESER_FACTOR (6),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rx_low_acc = 0;

  // datapath model: align_match rises once match_after slips have been seen
  int slips_seen  = 0;
  int slips_base  = 0;
  int match_after = 99;
  bit prev_slip   = 1'b0;
  bit slip_viol   = 1'b0;

  always @(negedge clk) begin
    if (bus.bitslip === 1'b1) begin
      slips_seen++;
      if (prev_slip || int'(bus.state) != S_ALIGN) slip_viol = 1'b1;
    end
    prev_slip = (bus.bitslip === 1'b1);
    bus.align_match = ((slips_seen - slips_base) >= match_after);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int n = 0;
    while (int'(bus.state) != st && n < budget) begin
      if (bus.rx_rst !== 1'b1) rx_low_acc++;
      @(negedge clk);
      n++;
    end
    chk(tag, int'(bus.state), st);
  endtask

  task automatic measure_run(input int st, input int budget, input string tag, output int len);
    wait_state(st, budget, tag);
    len = 0;
    while (int'(bus.state) == st && len < budget) begin
      if (bus.rx_rst !== 1'b1) rx_low_acc++;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_pll(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (bus.pll_rst !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(bus.pll_rst), int'(lvl));
  endtask

  task automatic level_run(input logic lvl, input int budget, output int len);
    len = 0;
    while (bus.pll_rst === lvl && len < budget) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int lat;
    int n;
    int rx_base;

    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.realign    = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_state",      int'(bus.state), S_RESET_PLL);
    chk("rst_pll_rst",    int'(bus.pll_rst), 1);
    chk("rst_rx_rst",     int'(bus.rx_rst), 1);
    chk("rst_bitslip",    int'(bus.bitslip), 0);
    chk("rst_ready",      int'(bus.ready), 0);
    chk("rst_align_fail", int'(bus.align_fail), 0);
    chk("rst_tcnt",       int'(bus.timeout_count), 0);
    chk("rst_rcnt",       int'(bus.relock_count), 0);

    // 1: bring-up, lock 10 clk after pll_rst falls, alignment after 3rd slip
    rst_n = 1'b1;
    wait_pll(1'b0, 20, "bringup_pll_rst_fall");
    repeat (10) @(negedge clk);
    bus.pll_locked = 1'b1;
    slips_base  = slips_seen;
    match_after = 3;
    push_exp("bringup_slips", 3);
    push_exp("bringup_ready", 1);
    push_exp("bringup_rx_rst", 0);
    push_exp("bringup_tcnt", 0);
    push_exp("bringup_rcnt", 0);
    push_exp("bringup_afail", 0);
    wait_state(S_READY, 200, "bringup_reach_ready");
    pop_chk(slips_seen - slips_base);
    pop_chk(int'(bus.ready));
    pop_chk(int'(bus.rx_rst));
    pop_chk(int'(bus.timeout_count));
    pop_chk(int'(bus.relock_count));
    pop_chk(int'(bus.align_fail));

    // 4: lock loss in READY
    bus.pll_locked = 1'b0;
    push_exp("loss_latency", 3);
    push_exp("loss_rcnt", 1);
    push_exp("loss_rerun_slips", 3);
    push_exp("loss_rerun_ready", 1);
    push_exp("loss_rerun_rcnt", 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.pll_rst === 1'b1 && bus.rx_rst === 1'b1 && bus.ready === 1'b0) && lat < 8);
    pop_chk(lat);
    pop_chk(int'(bus.relock_count));
    wait_pll(1'b0, 20, "loss_pll_rst_fall");
    repeat (10) @(negedge clk);
    bus.pll_locked = 1'b1;
    slips_base  = slips_seen;
    match_after = 3;
    wait_state(S_READY, 200, "loss_rerun_reach_ready");
    pop_chk(slips_seen - slips_base);
    pop_chk(int'(bus.ready));
    pop_chk(int'(bus.relock_count));

    // 5: never aligned, then realign out of ALIGN_FAIL
    match_after = 99;
    slips_base  = slips_seen;
    bus.realign = 1'b1;
    @(negedge clk);
    bus.realign = 1'b0;
    push_exp("fail_slips", 5);
    push_exp("fail_flag", 1);
    push_exp("fail_ready", 0);
    push_exp("realign_afail_clear", 0);
    push_exp("realign_rx_rst_len", 3);
    push_exp("realign_rx_held", 0);
    push_exp("realign_align_entered", S_ALIGN);
    wait_state(S_ALIGN_FAIL, 200, "fail_reach_align_fail");
    pop_chk(slips_seen - slips_base);
    pop_chk(int'(bus.align_fail));
    pop_chk(int'(bus.ready));
    bus.realign = 1'b1;
    @(negedge clk);
    bus.realign = 1'b0;
    pop_chk(int'(bus.align_fail));
    rx_base = rx_low_acc;
    measure_run(S_RX_RST, 10, "realign_rx_rst_entry", len);
    pop_chk(len);
    pop_chk(rx_low_acc - rx_base);
    pop_chk(int'(bus.state));

    // 6: asynchronous reset mid-ALIGN
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state",      int'(bus.state), S_RESET_PLL);
    chk("arst_pll_rst",    int'(bus.pll_rst), 1);
    chk("arst_rx_rst",     int'(bus.rx_rst), 1);
    chk("arst_bitslip",    int'(bus.bitslip), 0);
    chk("arst_ready",      int'(bus.ready), 0);
    chk("arst_align_fail", int'(bus.align_fail), 0);
    chk("arst_rcnt",       int'(bus.relock_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_restart_state", int'(bus.state), S_RESET_PLL);
    chk("arst_restart_pll_rst", int'(bus.pll_rst), 1);

    // 3: one-cycle lock glitch at the 5th STABLE cycle
    match_after = 0;
    wait_state(S_STABLE, 40, "glitch_stable_entry");
    repeat (4) @(negedge clk);
    bus.pll_locked = 1'b0;
    push_exp("glitch_restable_len", 8);
    push_exp("glitch_rx_rst_len", 3);
    push_exp("glitch_rx_held", 0);
    push_exp("glitch_align_entered", S_ALIGN);
    push_exp("glitch_rcnt", 0);
    @(negedge clk);
    bus.pll_locked = 1'b1;
    rx_base = rx_low_acc;
    wait_state(S_WAIT_LOCK, 10, "glitch_back_to_wait_lock");
    measure_run(S_STABLE, 20, "glitch_restable_entry", len);
    pop_chk(len);
    measure_run(S_RX_RST, 10, "glitch_rx_rst_entry", len);
    pop_chk(len);
    pop_chk(rx_low_acc - rx_base);
    pop_chk(int'(bus.state));
    pop_chk(int'(bus.relock_count));

    // 2: no lock at all
    bus.pll_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_exp("nolock_low_len", 20);
      push_exp("nolock_tcnt", p + 1);
      push_exp("nolock_high_len", 4);
    end
    wait_pll(1'b0, 20, "nolock_first_fall");
    for (int p = 0; p < 3; p++) begin
      level_run(1'b0, 40, len);
      pop_chk(len);
      pop_chk(int'(bus.timeout_count));
      level_run(1'b1, 10, len);
      pop_chk(len);
    end

    // timeout counter saturation
    n = 0;
    while (bus.timeout_count !== 8'hFF && n < 8000) begin
      @(negedge clk);
      n++;
    end
    repeat (60) @(negedge clk);
    chk("tcnt_saturate", int'(bus.timeout_count), 255);
    chk("nolock_rcnt", int'(bus.relock_count), 0);

    chk("bitslip_rules", int'(slip_viol), 0);
    chk("scoreboard_leftover", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
